// File: rtl/segre_fetch_unit.sv
// Instruction fetch unit: single-outstanding I-cache requester feeding an
// in-order fetch queue of {pc, instr}, with redirect flush and stale-response drain.
module segre_fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INSTR_W  = 32,
    parameter int unsigned       FQ_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                      clk_i,
    input  logic                      rsn_i,
    output logic                      ic_req_o,
    output logic [ADDR_W-1:0]         ic_addr_o,
    input  logic                      ic_gnt_i,
    input  logic                      ic_rvalid_i,
    input  logic [INSTR_W-1:0]        ic_rdata_i,
    input  logic                      redirect_i,
    input  logic [ADDR_W-1:0]         redirect_pc_i,
    output logic                      instr_valid_o,
    output logic [INSTR_W-1:0]        instr_o,
    output logic [ADDR_W-1:0]         pc_o,
    input  logic                      id_ready_i,
    output logic                      hazard_o,
    output logic [$clog2(FQ_DEPTH):0] fq_count_o
);

    localparam int unsigned       PTR_W   = $clog2(FQ_DEPTH);
    localparam int unsigned       CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FQ_DEPTH);
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(4);

    typedef enum logic [1:0] {FE_IDLE, FE_REQ, FE_WAIT, FE_DRAIN} fe_state_e;

    fe_state_e          state;
    logic [ADDR_W-1:0]  fetch_pc;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_nxt;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [ADDR_W-1:0]  pc_mem    [FQ_DEPTH];
    logic [INSTR_W-1:0] instr_mem [FQ_DEPTH];
    logic               resp;
    logic               push;
    logic               pop;

    // Redirect overrides both ends of the queue; the flush is handled in the FSM.
    assign resp = (state == FE_WAIT) && ic_rvalid_i;
    assign push = resp && !redirect_i;
    assign pop  = (count != '0) && id_ready_i && !redirect_i;

    always_comb begin
        count_nxt = count + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state    <= FE_REQ;
            fetch_pc <= RESET_PC;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else if (redirect_i) begin
            fetch_pc <= redirect_pc_i;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            // A request granted now, or still awaiting its response, must be drained.
            case (state)
                FE_WAIT:  state <= ic_rvalid_i ? FE_REQ : FE_DRAIN;
                FE_REQ:   state <= ic_gnt_i    ? FE_DRAIN : FE_REQ;
                FE_DRAIN: state <= ic_rvalid_i ? FE_REQ : FE_DRAIN;
                default:  state <= FE_REQ;
            endcase
        end else begin
            count <= count_nxt;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case (state)
                FE_IDLE: begin
                    if (count < DEPTH_C) state <= FE_REQ;
                end
                FE_REQ: begin
                    if (ic_gnt_i) begin
                        state    <= FE_WAIT;
                        fetch_pc <= fetch_pc + STEP;
                    end
                end
                FE_WAIT: begin
                    if (ic_rvalid_i) state <= (count_nxt < DEPTH_C) ? FE_REQ : FE_IDLE;
                end
                FE_DRAIN: begin
                    if (ic_rvalid_i) state <= FE_REQ;
                end
                default: state <= FE_REQ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            for (int unsigned i = 0; i < FQ_DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (push) begin
            pc_mem[wr_ptr]    <= fetch_pc - STEP;
            instr_mem[wr_ptr] <= ic_rdata_i;
        end
    end

    // Reset state is FE_REQ, so the request is masked while reset is held.
    assign ic_req_o      = (state == FE_REQ) && rsn_i;
    assign ic_addr_o     = fetch_pc;
    assign instr_valid_o = (count != '0);
    assign instr_o       = instr_mem[rd_ptr];
    assign pc_o          = pc_mem[rd_ptr];
    assign hazard_o      = (count == '0) && !resp;
    assign fq_count_o    = count;

endmodule

// File: doc/segre_fetch_unit.md
SEGRE_FETCH_UNIT -- requirements
Module: segre_fetch_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning fetch address width.
REQ-002 The block SHALL have parameter INSTR_W, default 32, meaning instruction width.
REQ-003 The block SHALL have parameter FQ_DEPTH, default 4, meaning fetch-queue entries (power of 2, >=2).
REQ-004 The block SHALL have parameter RESET_PC, default 0, meaning first fetch address.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset: clk_i  in  1  clock (all state rising-edge).
REQ-006 rsn_i  in  1  asynchronous active-low reset.
REQ-007 ic_req_o  out  1  fetch request valid.
REQ-008 ic_addr_o  out  ADDR_W  fetch address; held stable while ic_req_o=1 and ic_gnt_i=0.
REQ-009 ic_gnt_i  in  1  request accepted this cycle.
REQ-010 ic_rvalid_i  in  1  response valid (one cycle per granted request, in order).
REQ-011 ic_rdata_i  in  INSTR_W  response instruction.
REQ-012 redirect_i  in  1  taken branch/exception redirect.
REQ-013 redirect_pc_i  in  ADDR_W  redirect target.
REQ-014 instr_valid_o  out  1  queue head valid.
REQ-015 instr_o  out  INSTR_W  queue head instruction.
REQ-016 pc_o  out  ADDR_W  queue head PC.
REQ-017 id_ready_i  in  1  decode accepts head this cycle.
REQ-018 hazard_o  out  1  fetch starved: queue empty and no response arriving.
REQ-019 fq_count_o  out  clog2(FQ_DEPTH)+1  current queue occupancy.

Function
REQ-020 States SHALL be FE_IDLE, FE_REQ, FE_WAIT, FE_DRAIN; at most one request outstanding.
REQ-021 ic_req_o SHALL equal (state==FE_REQ); ic_addr_o SHALL equal fetch_pc.
REQ-022 FE_IDLE -> FE_REQ when fq_count < FQ_DEPTH (space reserved for the response).
REQ-023 FE_REQ: on ic_gnt_i -> FE_WAIT, fetch_pc <= fetch_pc+4 (wraps modulo 2^ADDR_W); else hold.
REQ-024 FE_WAIT: on ic_rvalid_i push {fetch_pc-4 as issued, ic_rdata_i}; next FE_REQ if occupancy after push/pop < FQ_DEPTH, else FE_IDLE.
REQ-025 FE_DRAIN: on ic_rvalid_i discard data, -> FE_REQ; else hold.
REQ-026 Pop SHALL occur when instr_valid_o && id_ready_i; instr_valid_o = (fq_count!=0); instr_o/pc_o from head entry, registered storage.
REQ-027 Simultaneous push and pop SHALL leave fq_count unchanged; pointers wrap modulo FQ_DEPTH.
REQ-028 Push SHALL never occur when full; pop SHALL be ignored when empty.
REQ-029 redirect_i SHALL take priority over push, pop and grant: queue flushed (count 0 next cycle), fetch_pc <= redirect_pc_i.
REQ-030 Redirect in FE_WAIT without ic_rvalid_i, or in FE_REQ with ic_gnt_i, SHALL go to FE_DRAIN; otherwise (including FE_DRAIN) -> FE_REQ if no stale request remains outstanding.
REQ-031 Redirect in FE_WAIT with ic_rvalid_i same cycle SHALL discard that response and go to FE_REQ.
REQ-032 Redirect with the same-cycle pop: pop SHALL have no effect beyond the flush.
REQ-033 hazard_o SHALL equal (fq_count==0) && !(state==FE_WAIT && ic_rvalid_i).

Reset
REQ-034 On rsn_i=0 asynchronously: state FE_REQ, fetch_pc=RESET_PC, fq_count=0, pointers 0.
REQ-035 During reset ic_req_o, instr_valid_o SHALL be 0, hazard_o 1, fq_count_o 0; instr_o/pc_o 0.
REQ-036 Reset mid-transaction SHALL drop any outstanding request; a late ic_rvalid_i after reset release while in FE_REQ SHALL be ignored.

Verification
REQ-037 Reset release, ic_gnt_i=1 constant, 1-cycle response latency, id_ready_i=0 -> addresses 0x0,0x4,0x8,0xC issued, fq_count_o reaches 4, ic_req_o drops, no 5th request.
REQ-038 Full queue then id_ready_i=1 for one cycle -> head pc_o 0x0 popped, count 3, FE_IDLE -> FE_REQ, next ic_addr_o 0x10.
REQ-039 redirect_i=1, redirect_pc_i=0x100 while FE_WAIT, response arrives next cycle -> response discarded (FE_DRAIN), count 0, next ic_addr_o 0x100, first pushed pc_o 0x100.
REQ-040 Redirect coincident with ic_rvalid_i and pop with 2 entries -> count 0 next cycle, no push, next request 0x100.
REQ-041 fetch_pc=0xFFFFFFFC granted -> next ic_addr_o 0x0 (wrap).
REQ-042 Assert rsn_i=0 during FE_WAIT -> outputs at reset values immediately; after release first ic_addr_o = RESET_PC.
